// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the KGP-RISC shifter: decodes shift type/amount, holds up to two entries
// in a main+skid buffer, counts issued shifts. Optional build macro SHAMT_CLAMP_EN clamps variable shamt at 32.
module shift_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_func,
  input  logic [DW-1:0] in_rt,
  input  logic [DW-1:0] in_rs,
  input  logic [4:0]    in_imm,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_A,
  output logic [DW-1:0] out_shamt,
  output logic          out_right,
  output logic          out_arith,
  output logic [RW-1:0] out_rd,
  output logic          illegal,
  output logic [CW-1:0] issue_cnt
);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] shamt;
    logic          right;
    logic          arith;
    logic [RW-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e        state_q, state_d;
  entry_t        main_q, main_d, skid_q, skid_d, new_e;
  logic          in_ready_q, in_ready_d;
  logic          illegal_q, illegal_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          legal, take, push, drain;

  assign legal = (in_func <= 3'd5);
  assign take  = in_valid & in_ready_q & ~flush;
  assign push  = take & legal;
  assign drain = (state_q != EMPTY) & out_ready;

`ifndef SHAMT_CLAMP_EN
  logic unused_rs_hi;
  assign unused_rs_hi = ^in_rs[DW-1:5];
`endif

  always_comb begin
    new_e       = '0;
    new_e.a     = in_rt;
    new_e.rd    = in_rd;
    new_e.right = 1'b0;
    new_e.arith = 1'b0;
    case (in_func)
      3'd1, 3'd4: new_e.right = 1'b1;
      3'd2, 3'd5: begin
        new_e.right = 1'b1;
        new_e.arith = 1'b1;
      end
      default: ;
    endcase
    if (in_func < 3'd3) begin
      new_e.shamt = DW'(in_imm);
    end else begin
`ifdef SHAMT_CLAMP_EN
      // Anything >= 32 saturates so the shifter fully drains the operand.
      new_e.shamt = (in_rs >= DW'(32)) ? DW'(32) : in_rs;
`else
      new_e.shamt = DW'(in_rs[4:0]);
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (push) begin
        main_d  = new_e;
        state_d = ONE;
      end
      ONE: begin
        if (push && drain) begin
          main_d = new_e;
        end else if (push) begin
          skid_d  = new_e;
          state_d = TWO;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: if (drain) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d = (state_d != TWO);
    illegal_d  = take & ~legal;
    // Counter is deliberately insensitive to flush.
    cnt_d = cnt_q;
    if (drain && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_A     = main_q.a;
  assign out_shamt = main_q.shamt;
  assign out_right = main_q.right;
  assign out_arith = main_q.arith;
  assign out_rd    = main_q.rd;
  assign illegal   = illegal_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: expected entries queued at input handshake, compared at output handshake.
module tb_shift_issue_stage;
  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_func;
  logic [31:0] in_rt, in_rs, out_A, out_shamt;
  logic [4:0]  in_imm, in_rd, out_rd;
  logic        out_right, out_arith, illegal;
  logic [15:0] issue_cnt;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] shamt;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  bit          mon_en = 0;
  logic [15:0] exp_cnt = 0;

  shift_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rt(in_rt), .in_rs(in_rs), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_shamt(out_shamt),
    .out_right(out_right), .out_arith(out_arith), .out_rd(out_rd), .illegal(illegal),
    .issue_cnt(issue_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] rt, input logic [31:0] rs,
                                 input logic [4:0] imm, input logic [4:0] rd);
    exp_t e;
    e.a = rt;
    e.rd = rd;
    e.right = (f != 3'd0) && (f != 3'd3);
    e.arith = (f == 3'd2) || (f == 3'd5);
    if (f <= 3'd2) e.shamt = {27'b0, imm};
`ifdef SHAMT_CLAMP_EN
    else e.shamt = (rs > 32'd31) ? 32'd32 : rs;
`else
    else e.shamt = rs % 32;
`endif
    return e;
  endfunction

  // Monitor: sample mid-cycle, ahead of the edge that completes the handshakes.
  always @(negedge clk) if (mon_en) begin
    chk("issue_cnt", {48'b0, issue_cnt}, {48'b0, exp_cnt});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexp_out", {63'b0, out_valid}, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_A", {32'b0, out_A}, {32'b0, e.a});
        chk("out_shamt", {32'b0, out_shamt}, {32'b0, e.shamt});
        chk("out_right", {63'b0, out_right}, {63'b0, e.right});
        chk("out_arith", {63'b0, out_arith}, {63'b0, e.arith});
        chk("out_rd", {59'b0, out_rd}, {59'b0, e.rd});
      end
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready && in_func <= 3'd5)
      sb.push_back(model(in_func, in_rt, in_rs, in_imm, in_rd));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one entry until accepted (bounded), then drop in_valid.
  task automatic send(input logic [2:0] f, input logic [31:0] rt, input logic [31:0] rs,
                      input logic [4:0] imm, input logic [4:0] rd);
    bit acc = 0;
    in_valid = 1; in_func = f; in_rt = rt; in_rs = rs; in_imm = imm; in_rd = rd;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      cyc(1);
    end
    if (!acc) chk("send_timeout", {63'b0, in_ready}, 64'd1);
    in_valid = 0;
  endtask

  initial begin
    logic [15:0] cnt_save;
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_func = 0; in_rt = 0; in_rs = 0; in_imm = 0; in_rd = 0;
    cyc(2);
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_illegal", {63'b0, illegal}, 64'd0);
    chk("rst_cnt", {48'b0, issue_cnt}, 64'd0);
    chk("rst_out_A", {32'b0, out_A}, 64'd0);
    chk("rst_shamt", {32'b0, out_shamt}, 64'd0);
    rst = 1;
    mon_en = 1;
    cyc(1);

    // shra immediate
    out_ready = 1;
    send(3'd2, 32'hCCC9CCC9, 32'd0, 5'd5, 5'd7);
    @(negedge clk);
    chk("t1_out_valid", {63'b0, out_valid}, 64'd1);
    chk("t1_out_A", {32'b0, out_A}, 64'hCCC9CCC9);
    chk("t1_shamt", {32'b0, out_shamt}, 64'd5);
    chk("t1_right_arith", {62'b0, out_right, out_arith}, 64'd3);
    chk("t1_rd", {59'b0, out_rd}, 64'd7);
    cyc(1);
    @(negedge clk);
    chk("t1_cnt", {48'b0, issue_cnt}, 64'd1);
    cyc(1);

    // shllv with rs=40
    send(3'd3, 32'h1234, 32'd40, 5'd9, 5'd2);
    @(negedge clk);
`ifdef SHAMT_CLAMP_EN
    chk("t2_shamt", {32'b0, out_shamt}, 64'd32);
`else
    chk("t2_shamt", {32'b0, out_shamt}, 64'd8);
`endif
    chk("t2_right_arith", {62'b0, out_right, out_arith}, 64'd0);
    cyc(3);

    // Backpressure: three shrl entries with out_ready low
    out_ready = 0;
    in_valid = 1; in_func = 3'd1; in_rt = 32'hA5A5_0001; in_rd = 5'd1; in_imm = 5'd1;
    @(negedge clk); chk("bp_rdy1", {63'b0, in_ready}, 64'd1); cyc(1);
    in_imm = 5'd2; in_rd = 5'd2;
    @(negedge clk); chk("bp_rdy2", {63'b0, in_ready}, 64'd1); cyc(1);
    in_imm = 5'd3; in_rd = 5'd3;
    @(negedge clk);
    chk("bp_rdy3", {63'b0, in_ready}, 64'd0);
    chk("bp_hold1", {32'b0, out_shamt}, 64'd1);
    cyc(2);
    @(negedge clk);
    chk("bp_hold2", {32'b0, out_shamt}, 64'd1);
    chk("bp_rdy4", {63'b0, in_ready}, 64'd0);
    out_ready = 1;
    send(3'd1, 32'hA5A5_0001, 32'd0, 5'd3, 5'd3);
    cyc(4);
    @(negedge clk);
    chk("bp_drained", {63'b0, out_valid}, 64'd0);

    // Illegal func
    cnt_save = issue_cnt;
    cyc(1);
    in_valid = 1; in_func = 3'd6;
    @(negedge clk);
    chk("ill_rdy", {63'b0, in_ready}, 64'd1);
    chk("ill_pre", {63'b0, illegal}, 64'd0);
    cyc(1);
    in_valid = 0;
    @(negedge clk);
    chk("ill_pulse", {63'b0, illegal}, 64'd1);
    chk("ill_out_valid", {63'b0, out_valid}, 64'd0);
    cyc(1);
    @(negedge clk);
    chk("ill_end", {63'b0, illegal}, 64'd0);
    chk("ill_cnt", {48'b0, issue_cnt}, {48'b0, cnt_save});
    cyc(1);

    // Flush in TWO with an input offered
    out_ready = 0;
    send(3'd0, 32'h11, 32'd0, 5'd4, 5'd4);
    send(3'd0, 32'h22, 32'd0, 5'd5, 5'd5);
    in_valid = 1; in_func = 3'd0; in_imm = 5'd6; in_rd = 5'd6; flush = 1;
    @(negedge clk);
    chk("fl_two_rdy", {63'b0, in_ready}, 64'd0);
    cyc(1);
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("fl_out_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1;
    cyc(3);

    // Back-to-back streaming with random operands
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_func = 3'($urandom_range(0, 5));
      in_rt = $urandom; in_rs = $urandom_range(0, 63);
      in_imm = 5'($urandom_range(0, 31)); in_rd = 5'(i);
      @(negedge clk);
      chk("stream_rdy", {63'b0, in_ready}, 64'd1);
      cyc(1);
    end
    in_valid = 0;
    cyc(3);

    // Async reset mid-stream
    out_ready = 0;
    send(3'd4, 32'hDEAD, 32'd3, 5'd0, 5'd9);
    @(negedge clk);
    chk("ar_valid_pre", {63'b0, out_valid}, 64'd1);
    mon_en = 0;
    #2 rst = 0;
    #1;
    chk("ar_out_valid", {63'b0, out_valid}, 64'd0);
    chk("ar_cnt", {48'b0, issue_cnt}, 64'd0);
    chk("ar_out_A", {32'b0, out_A}, 64'd0);
    chk("ar_in_ready", {63'b0, in_ready}, 64'd1);
    sb.delete();
    exp_cnt = 0;
    cyc(2);
    rst = 1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
